// File: rtl/debounce_scan_ctrl_pkg.sv
// Shared types and constants for the time-multiplexed debounce scanner.
package debounce_scan_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [2:0] PAT_PRESS   = 3'b011;
  localparam logic [2:0] PAT_RELEASE = 3'b100;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_scan_ctrl_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads as zero when nothing is queued so the id output has a defined idle value.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// One shared sampling engine debounces N inputs on a slow tick and queues press events for the CPU.
module debounce_scan_ctrl
  import debounce_scan_ctrl_pkg::*;
#(
  parameter int  N_INPUTS   = 4,
  parameter int  TICK_DIV   = 50000,
  parameter int  FIFO_DEPTH = 4,
  localparam int ID_W       = id_width(N_INPUTS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_INPUTS-1:0] i_btn,
  input  logic [N_INPUTS-1:0] i_mask,
  output logic [N_INPUTS-1:0] o_pressed,
  output logic                o_evt_valid,
  output logic [ID_W-1:0]     o_evt_id,
  input  logic                i_evt_ready,
  output logic                o_overflow,
  input  logic                i_clr_overflow
);

  localparam int             CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_INPUTS - 1);

  logic [N_INPUTS-1:0] sync_p0;
  logic [N_INPUTS-1:0] sync_p1;
  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  state_t              state;
  logic [ID_W-1:0]     idx;
  logic [2:0]          hist [N_INPUTS];
  logic [2:0]          hist_new;
  logic                push_vld;
  logic                pop_vld;
  logic                fifo_full;
  logic                fifo_empty;

  // Stage p0/p1: two-flop synchronizer on the raw pins
  always_ff @(posedge i_clk) begin
    sync_p0 <= i_btn;
    sync_p1 <= sync_p0;
  end

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Stage scan: shift one synchronized sample into the selected history per cycle
  assign hist_new = {hist[idx][1:0], sync_p1[idx]};
  assign push_vld = (state == ST_SCAN) && (hist_new == PAT_PRESS) && i_mask[idx];
  assign pop_vld  = o_evt_valid && i_evt_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      o_pressed <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        hist[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_SCAN;
            idx   <= '0;
          end
        end
        ST_SCAN: begin
          hist[idx] <= hist_new;
          if (hist_new == PAT_PRESS) begin
            o_pressed[idx] <= 1'b1;
          end else if (hist_new == PAT_RELEASE) begin
            o_pressed[idx] <= 1'b0;
          end
          if (idx == LAST_IDX) begin
            state <= ST_IDLE;
          end else begin
            idx <= idx + ID_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
    end else if (push_vld && fifo_full && !pop_vld) begin
      o_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      o_overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push_vld),
    .pop     (pop_vld),
    .wr_data (idx),
    .rd_data (o_evt_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_evt_valid = !fifo_empty;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl with TICK_DIV=8, N_INPUTS=4, FIFO_DEPTH=2.
module tb_debounce_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] mask;
  logic [3:0] pressed;
  logic       valid;
  logic [1:0] id;
  logic       ready;
  logic       overflow;
  logic       clr;

  int n_cmp  = 0;
  int n_fail = 0;
  int phase  = 0;

  debounce_scan_ctrl #(
    .N_INPUTS   (4),
    .TICK_DIV   (8),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_btn          (btn),
    .i_mask         (mask),
    .o_pressed      (pressed),
    .o_evt_valid    (valid),
    .o_evt_id       (id),
    .i_evt_ready    (ready),
    .o_overflow     (overflow),
    .i_clr_overflow (clr)
  );

  always #5 clk = ~clk;

  // Phase 0 is the falling edge just after the last scan cycle of a tick.
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    phase = (phase + n) % 8;
  endtask

  task automatic align();
    adv((8 - phase) % 8);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btn = 4'h0; mask = 4'hF; ready = 1'b0; clr = 1'b0;
    adv(5);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_pressed", 32'(pressed), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    rst = 1'b0;
    phase = 4;
    adv(12);

    // Quiet inputs for ~100 cycles
    adv(96);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_pressed", 32'(pressed), 32'd0);
    check("idle_overflow", 32'(overflow), 32'd0);

    // Steady press on input 2
    btn[2] = 1'b1;
    adv(8);
    check("p2_early_pressed", 32'(pressed), 32'd0);
    check("p2_early_valid", 32'(valid), 32'd0);
    adv(8);
    check("p2_pressed", 32'(pressed), 32'h4);
    check("p2_valid", 32'(valid), 32'd1);
    check("p2_id", 32'(id), 32'd2);
    adv(20);
    check("p2_hold_id", 32'(id), 32'd2);
    check("p2_hold_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    adv(1);
    ready = 1'b0;
    check("p2_popped_valid", 32'(valid), 32'd0);
    btn[2] = 1'b0;
    align();
    adv(16);
    check("p2_release", 32'(pressed), 32'd0);
    adv(8);

    // One-tick glitch on input 1
    btn[1] = 1'b1;
    adv(8);
    btn[1] = 1'b0;
    adv(24);
    check("glitch_pressed", 32'(pressed), 32'd0);
    check("glitch_valid", 32'(valid), 32'd0);

    // Masked input 0
    mask = 4'b1110;
    btn[0] = 1'b1;
    adv(16);
    check("mask_pressed", 32'(pressed), 32'h1);
    check("mask_valid", 32'(valid), 32'd0);
    btn[0] = 1'b0;
    adv(16);
    check("mask_release", 32'(pressed), 32'd0);
    mask = 4'hF;
    adv(8);

    // All four pressed into a two-entry FIFO
    btn = 4'hF;
    adv(16);
    check("ovf_pressed", 32'(pressed), 32'hF);
    check("ovf_valid", 32'(valid), 32'd1);
    check("ovf_id", 32'(id), 32'd0);
    check("ovf_set", 32'(overflow), 32'd1);
    clr = 1'b1;
    adv(1);
    clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_keep_id", 32'(id), 32'd0);
    btn = 4'h0;
    align();
    adv(24);
    check("ovf_release", 32'(pressed), 32'd0);

    // Pop coincides with the push of input 3 while full
    btn = 4'b1000;
    adv(8);
    adv(7);
    ready = 1'b1;
    adv(1);
    ready = 1'b0;
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_valid", 32'(valid), 32'd1);
    check("pp_id", 32'(id), 32'd1);
    check("pp_pressed", 32'(pressed), 32'h8);
    ready = 1'b1;
    adv(1);
    check("pp_second_id", 32'(id), 32'd3);
    adv(1);
    ready = 1'b0;
    check("pp_drained", 32'(valid), 32'd0);
    btn = 4'h0;
    align();
    adv(24);

    // Reset mid-scan with two events queued
    btn = 4'b0011;
    adv(16);
    check("mr_valid_pre", 32'(valid), 32'd1);
    check("mr_id_pre", 32'(id), 32'd0);
    check("mr_pressed_pre", 32'(pressed), 32'h3);
    adv(5);
    rst = 1'b1;
    adv(1);
    check("mr_valid", 32'(valid), 32'd0);
    check("mr_pressed", 32'(pressed), 32'd0);
    check("mr_overflow", 32'(overflow), 32'd0);
    check("mr_id", 32'(id), 32'd0);
    rst = 1'b0;
    adv(16);
    check("mr_before_evt", 32'(valid), 32'd0);
    adv(1);
    check("mr_first_evt", 32'(valid), 32'd1);
    check("mr_first_id", 32'(id), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
